// File: rtl/dot_product_pkg.sv
// -----------------------------------------------------------------------------
// dot_product_pkg
// Shared definitions for the dot-product sequencer:
//   state_t    - sequencer FSM state encoding
//   acc_width  - accumulator width that cannot overflow while summing
//                vec_len products of two data_width-bit unsigned operands
// -----------------------------------------------------------------------------
package dot_product_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Each product needs 2*data_width bits; summing vec_len of them adds
    // clog2(vec_len) carry bits.
    function automatic int acc_width(input int data_width, input int vec_len);
        return 2 * data_width + $clog2(vec_len);
    endfunction

endpackage

// File: rtl/dot_product_sequencer_if.sv
// -----------------------------------------------------------------------------
// dot_product_sequencer_if
// Memory-side bus of the dot-product sequencer.
//   rd_en / rd_addr        - read strobe and address shared by both source memories
//   rd_data_a / rd_data_b  - source words, valid the cycle after rd_en
//   wr_en / wr_addr        - result memory write strobe and address
//   wr_data                - result word
// master: the sequencer; slave: the memories.
// -----------------------------------------------------------------------------
interface dot_product_sequencer_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int RESULT_WIDTH = 32
);

    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data_a;
    logic [DATA_WIDTH-1:0]   rd_data_b;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [RESULT_WIDTH-1:0] wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data_a, rd_data_b
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data_a, rd_data_b
    );

endinterface

// File: rtl/dot_product_sequencer_mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
// Unsigned multiply-accumulate register.
//   clk, rst_n - clock, synchronous active-low reset
//   clear      - zero the accumulator (takes priority over en)
//   en         - add a*b to the accumulator this cycle
//   a, b       - unsigned operands
//   acc        - accumulator value
// -----------------------------------------------------------------------------
module mac_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 66
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic [2*DATA_WIDTH-1:0] product;

    // Operands widened first so the multiply keeps the full product.
    assign product = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values; reset is synchronous (checked only on the clock edge).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_WIDTH'(product);
        end
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// -----------------------------------------------------------------------------
// dot_product_sequencer
// Reads VEC_LEN word pairs from two source memories at base_addr+k, sums their
// unsigned products and writes the result to the next slot of a result memory.
//   clk, rst_n - clock, synchronous active-low reset
//   start      - one-cycle request, accepted only when idle
//   base_addr  - first source address, sampled with start
//   mem        - memory bus (master side)
//   busy       - operation in progress (cycle after start through DONE)
//   done       - one-cycle completion pulse
//   overflow   - last result did not fit in RESULT_WIDTH; held until next start
// -----------------------------------------------------------------------------
module dot_product_sequencer
    import dot_product_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int RESULT_WIDTH = 32,
    parameter int VEC_LEN      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    dot_product_sequencer_if.master mem,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, VEC_LEN);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VEC_LEN - 1);

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  rd_valid_q;
    logic                  ovf_q;
    logic                  accept;
    logic [ACC_WIDTH-1:0]  acc;

    assign accept   = (state == IDLE) && start;
    assign overflow = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        next_state   = state;
        busy         = 1'b1;
        done         = 1'b0;
        mem.rd_en    = 1'b0;
        mem.rd_addr  = '0;
        mem.wr_en    = 1'b0;
        mem.wr_addr  = '0;
        mem.wr_data  = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = READ;
            end
            READ: begin
                mem.rd_en   = 1'b1;
                mem.rd_addr = base_q + idx;   // wraps modulo 2^ADDR_WIDTH
                if (idx == LAST_IDX) next_state = DRAIN;
            end
            DRAIN: begin
                // Last read's data is being accumulated this cycle.
                next_state = WRITE;
            end
            WRITE: begin
                mem.wr_en   = 1'b1;
                mem.wr_addr = ptr + ADDR_WIDTH'(1);
                mem.wr_data = acc[RESULT_WIDTH-1:0];
                next_state  = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q     <= '0;
            idx        <= '0;
            ptr        <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            // Read data arrives one cycle after the strobe.
            rd_valid_q <= (state == READ);
            if (accept) begin
                base_q <= base_addr;
                idx    <= '0;
                ovf_q  <= 1'b0;
            end else if (state == READ) begin
                idx <= idx + ADDR_WIDTH'(1);
            end
            if (state == WRITE) begin
                ptr   <= ptr + ADDR_WIDTH'(1);
                ovf_q <= |acc[ACC_WIDTH-1:RESULT_WIDTH];
            end
        end
    end

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .en    (rd_valid_q),
        .a     (mem.rd_data_a),
        .b     (mem.rd_data_b),
        .acc   (acc)
    );

endmodule

// File: tb/tb_dot_product_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dot_product_sequencer
// Scoreboard bench: issuing an operation pushes its expected reads and result;
// a monitor on the falling edge pops and compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_dot_product_sequencer;

    localparam int DW      = 32;
    localparam int AW      = 5;
    localparam int RW      = 32;
    localparam int VEC_LEN = 4;
    localparam int ACC_W   = 2 * DW + $clog2(VEC_LEN);
    localparam int DEPTH   = 1 << AW;

    typedef struct {
        int          start_cyc;
        logic [RW-1:0] data;
        logic [AW-1:0] addr;
        logic        ovf;
    } op_t;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
    } rd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy;
    logic          done;
    logic          overflow;

    dot_product_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESULT_WIDTH(RW)) bus ();

    dot_product_sequencer #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .RESULT_WIDTH (RW),
        .VEC_LEN      (VEC_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .mem       (bus),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Source memories: registered read, data valid the cycle after rd_en.
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= mem_a[bus.rd_addr];
            bus.rd_data_b <= mem_b[bus.rd_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    op_t op_q[$];
    rd_t rd_q[$];
    int            busy_end = 0;
    logic [AW-1:0] model_ptr = '0;
    logic          model_ovf = 1'b0;
    int            wr_count = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [RW-1:0] last_wr_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    op_t mon_op;
    rd_t mon_rd;
    always @(negedge clk) begin
        if (bus.rd_en) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", bus.rd_en, 0);
            end else begin
                mon_rd = rd_q.pop_front();
                check("rd_addr", bus.rd_addr, mon_rd.addr);
                check("rd_cycle", cyc, mon_rd.cyc);
            end
        end
        if (bus.wr_en) begin
            wr_count++;
            last_wr_addr = bus.wr_addr;
            last_wr_data = bus.wr_data;
            if (op_q.size() == 0) begin
                check("wr_unexpected", bus.wr_en, 0);
            end else begin
                mon_op = op_q[0];
                check("wr_data", bus.wr_data, mon_op.data);
                check("wr_addr", bus.wr_addr, mon_op.addr);
                check("wr_cycle", cyc, mon_op.start_cyc + VEC_LEN + 2);
            end
        end
        if (done) begin
            if (op_q.size() == 0) begin
                check("done_unexpected", done, 0);
            end else begin
                mon_op = op_q.pop_front();
                check("done_cycle", cyc, mon_op.start_cyc + VEC_LEN + 3);
                check("done_overflow", overflow, mon_op.ovf);
                check("busy_in_done", busy, 1);
            end
        end
    end

    // Reference: accepted only when no operation occupies the sequencer;
    // result is the plain sum of products over the wrapped address window.
    task automatic issue(input logic [AW-1:0] base);
        logic [ACC_W-1:0] sum;
        logic [AW-1:0]    a;
        op_t              o;
        rd_t              r;
        start     = 1'b1;
        base_addr = base;
        if (cyc >= busy_end) begin
            sum = '0;
            for (int k = 0; k < VEC_LEN; k++) begin
                a = base + AW'(k);
                sum += ACC_W'(mem_a[a]) * ACC_W'(mem_b[a]);
                r.cyc  = cyc + 1 + k;
                r.addr = a;
                rd_q.push_back(r);
            end
            model_ptr   = model_ptr + AW'(1);
            o.start_cyc = cyc;
            o.data      = sum[RW-1:0];
            o.addr      = model_ptr;
            o.ovf       = (sum >> RW) != 0;
            op_q.push_back(o);
            model_ovf   = o.ovf;
            busy_end    = cyc + VEC_LEN + 4;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < VEC_LEN + 10; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check("done_timeout", done, 1);
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("overflow_held", overflow, model_ovf);
    endtask

    task automatic run_op(input logic [AW-1:0] base);
        issue(base);
        wait_done();
        idle_check();
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
    endtask

    task automatic model_reset();
        op_q.delete();
        rd_q.delete();
        model_ptr = '0;
        model_ovf = 1'b0;
        busy_end  = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        fill_random();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: [1,2,3,4].[5,6,7,8] = 70, first result at address 1
        for (int k = 0; k < 4; k++) begin
            mem_a[k] = DW'(k + 1);
            mem_b[k] = DW'(k + 5);
        end
        run_op(5'd0);
        check("directed_data", last_wr_data, 70);
        check("directed_addr", last_wr_addr, 1);

        // Back-to-back: start in the first idle cycle after done
        run_op(5'd0);
        check("b2b_addr", last_wr_addr, 2);

        // Address wrap on reads: 30,31,0,1
        fill_random();
        run_op(5'd30);

        // Overflow, then cleared by a small operation
        for (int k = 10; k < 14; k++) begin
            mem_a[k] = '1;
            mem_b[k] = '1;
        end
        for (int k = 20; k < 24; k++) begin
            mem_a[k] = DW'(k);
            mem_b[k] = DW'(3);
        end
        run_op(5'd10);
        check("ovf_data", last_wr_data, 32'h0000_0004);
        check("ovf_flag", overflow, 1);
        run_op(5'd20);
        check("ovf_cleared", overflow, 0);

        // Start while busy is ignored
        wr_before = wr_count;
        issue(5'd5);
        @(negedge clk);
        issue(5'd7);
        wait_done();
        idle_check();
        check("single_write", wr_count - wr_before, 1);

        // Reset in cycle 3 aborts with no write
        issue(5'd3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        check_reset_outputs();
        rst_n = 1'b1;
        wr_before = wr_count;
        repeat (8) @(negedge clk);
        check("abort_no_write", wr_count - wr_before, 0);
        run_op(5'd12);
        check("after_abort_addr", last_wr_addr, 1);

        // Pointer wrap over 32 operations from a clean reset
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        fill_random();
        for (int n = 0; n < 32; n++) begin
            run_op(AW'($urandom_range(0, DEPTH - 1)));
        end
        check("wrap_last_addr", last_wr_addr, 0);

        repeat (2) @(negedge clk);
        check("op_queue_drained", op_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
